// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
// A round-robin grant picks one operation, its operands are registered
// onto the ALU inputs, and the ALU result is then captured and returned
// on a single response channel tagged with the requester id.
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A producer holds its payload
// stable while valid is high and not yet accepted. On the request side,
// valid may be withdrawn before acceptance and has no effect. reqN_ready
// depends only on the FSM state and the grant, never on the payload.
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Current FSM state; kept as a plainly named signal so checkers can bind to it.
  state_t           state;
  logic             last_grant;
  logic             id_q;
  logic             err_q;

  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_op;
  logic             sel_legal;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant = ~last_grant;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end else if (req0_valid) begin
      grant = 1'b0;
    end
  end

  // Ready only in IDLE and only for the granted requester; held low during reset.
  always_comb begin
    req0_ready = !reset && (state == IDLE) && !grant;
    req1_ready = !reset && (state == IDLE) && grant;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  end

  // Select the winning payload and check its ALUOp against the supported set.
  always_comb begin
    sel_a  = grant ? req1_a  : req0_a;
    sel_b  = grant ? req1_b  : req0_b;
    sel_op = grant ? req1_op : req0_op;
    case (sel_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100: sel_legal = 1'b1;
      default:                                     sel_legal = 1'b0;
    endcase
  end

  // Control FSM with registered ALU drive and registered response channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // An illegal op drives zeros so the ALU sees a harmless operation.
            alu_a      <= sel_legal ? sel_a  : '0;
            alu_b      <= sel_legal ? sel_b  : '0;
            alu_op     <= sel_legal ? sel_op : 4'b0000;
            id_q       <= grant;
            err_q      <= !sel_legal;
            last_grant <= grant;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_id     <= id_q;
          rsp_err    <= err_q;
          rsp_result <= err_q ? '0 : alu_result;
          rsp_zero   <= err_q ? 1'b0 : alu_zero;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          // Going back through IDLE keeps a response handshake and a new accept apart.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
